// File: rtl/cam_add_sequencer_if.sv
// Request/response handshake bundle for the CAM-lookup adder sequencer.
interface cam_add_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/cam_add_sequencer.sv
// Sequenced CAM-table adder: ripples one operand bit per cycle through a programmable
// 8-entry {a,b,c} -> {carry,sum} table and returns the result over a valid/ready handshake.
module cam_add_sequencer #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned NUM_CELL = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_we,
   input  logic [2:0]  cfg_addr,
   input  logic [1:0]  cfg_data,
   output logic        cfg_err,
   output logic        tbl_ready,
   output logic        busy,
   output logic [15:0] op_count,
   cam_add_sequencer_if.slave io
);

   localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                state_q, state_d;
   logic [1:0]            tbl_q [NUM_CELL];
   logic [1:0]            tbl_d [NUM_CELL];
   logic [NUM_CELL-1:0]   mask_q, mask_d;
   logic [WIDTH-1:0]      a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]      sum_q, sum_d;
   logic                  carry_q, carry_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [WIDTH-1:0]      res_sum_q, res_sum_d;
   logic                  res_cout_q, res_cout_d;
   logic                  cfg_err_q, cfg_err_d;
   logic [15:0]           op_count_q, op_count_d;
   logic [2:0]            key;
   logic [1:0]            ent;

   always_comb begin
      state_d    = state_q;
      tbl_d      = tbl_q;
      mask_d     = mask_q;
      a_d        = a_q;
      b_d        = b_q;
      sum_d      = sum_q;
      carry_d    = carry_q;
      idx_d      = idx_q;
      res_sum_d  = res_sum_q;
      res_cout_d = res_cout_q;
      cfg_err_d  = 1'b0;
      op_count_d = op_count_q;
      key        = 3'b000;
      ent        = 2'b00;
      unique case (state_q)
         StIdle: begin
            if (cfg_we) begin
               tbl_d[cfg_addr]  = cfg_data;
               mask_d[cfg_addr] = 1'b1;
            end
            // Acceptance uses the pre-edge mask; the first lookup sees the post-write table.
            if (io.in_valid && tbl_ready) begin
               a_d     = io.a;
               b_d     = io.b;
               carry_d = io.cin;
               idx_d   = '0;
               sum_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            cfg_err_d    = cfg_we;
            key          = {a_q[idx_q], b_q[idx_q], carry_q};
            ent          = tbl_q[key];
            sum_d[idx_q] = ent[0];
            carry_d      = ent[1];
            if (idx_q == LastIdx) begin
               res_sum_d  = sum_d;
               res_cout_d = ent[1];
               state_d    = StDone;
            end else begin
               idx_d = idx_q + IdxW'(1);
            end
         end
         StDone: begin
            cfg_err_d = cfg_we;
            if (io.out_ready) begin
               op_count_d = op_count_q + 16'd1;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         for (int i = 0; i < NUM_CELL; i++) tbl_q[i] <= 2'b00;
         mask_q     <= '0;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         carry_q    <= 1'b0;
         idx_q      <= '0;
         res_sum_q  <= '0;
         res_cout_q <= 1'b0;
         cfg_err_q  <= 1'b0;
         op_count_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         tbl_q      <= tbl_d;
         mask_q     <= mask_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sum_q      <= sum_d;
         carry_q    <= carry_d;
         idx_q      <= idx_d;
         res_sum_q  <= res_sum_d;
         res_cout_q <= res_cout_d;
         cfg_err_q  <= cfg_err_d;
         op_count_q <= op_count_d;
      end
   end

   assign tbl_ready    = &mask_q;
   assign io.in_ready  = (state_q == StIdle) && tbl_ready;
   assign io.out_valid = (state_q == StDone);
   assign io.sum       = res_sum_q;
   assign io.cout      = res_cout_q;
   assign busy         = (state_q != StIdle);
   assign cfg_err      = cfg_err_q;
   assign op_count     = op_count_q;

endmodule

// File: tb/tb_cam_add_sequencer.sv
// Directed and randomized checks of cam_add_sequencer against a table-driven ripple model.
module tb_cam_add_sequencer;
   localparam int unsigned WIDTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_addr = 3'd0;
   logic [1:0]  cfg_data = 2'd0;
   logic        cfg_err, tbl_ready, busy;
   logic [15:0] op_count;

   cam_add_sequencer_if #(.WIDTH(WIDTH)) io ();

   cam_add_sequencer #(.WIDTH(WIDTH), .NUM_CELL(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .cfg_err  (cfg_err),
      .tbl_ready(tbl_ready),
      .busy     (busy),
      .op_count (op_count),
      .io       (io)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0]       tbl_m [8];
   logic [7:0]       mask_m;
   logic [15:0]      cnt_m;
   logic [WIDTH-1:0] last_sum_m;
   logic             last_cout_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Ripple model: each bit looks up {a,b,carry} in the programmed table.
   function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                              input logic ci);
      logic [WIDTH-1:0] s;
      logic             c;
      int               k;
      s = '0;
      c = ci;
      for (int i = 0; i < WIDTH; i++) begin
         k    = {29'd0, av[i], bv[i], c};
         s[i] = tbl_m[k][0];
         c    = tbl_m[k][1];
      end
      return {c, s};
   endfunction

   function automatic logic [1:0] entry_for(input int kind, input int k);
      int pc;
      pc = $countones(k[2:0]);
      if (kind == 0) return {pc >= 2, pc[0]};
      if (kind == 1) return {1'b0, pc[0]};
      return 2'($urandom_range(0, 3));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) tbl_m[i] = 2'b00;
      mask_m      = 8'h00;
      cnt_m       = 16'd0;
      last_sum_m  = '0;
      last_cout_m = 1'b0;
   endtask

   task automatic cfg_write(input logic [2:0] ad, input logic [1:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = ad; cfg_data = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      tbl_m[ad]  = d;
      mask_m[ad] = 1'b1;
   endtask

   task automatic program_table(input int kind);
      for (int k = 0; k < 8; k++) cfg_write(3'(k), entry_for(kind, k));
      chk("tbl_ready_after_prog", tbl_ready, 1);
   endtask

   task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic ci, input logic [WIDTH-1:0] exp_s, input logic exp_c,
                         input int hold, input bit poke);
      int n;
      bit seen;
      @(negedge clk);
      io.a = av; io.b = bv; io.cin = ci; io.in_valid = 1'b1; io.out_ready = 1'b0;
      chk({tag, "_in_ready"}, io.in_ready, 1);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) begin
            io.in_valid = 1'b0;
            chk({tag, "_busy"}, busy, 1);
            if (poke) begin
               cfg_we = 1'b1; cfg_addr = 3'b111; cfg_data = 2'b00;
            end
         end
         if (poke && n == 2) begin
            chk({tag, "_cfg_err_pulse"}, cfg_err, 1);
            cfg_we = 1'b0;
         end
         if (poke && n == 3) chk({tag, "_cfg_err_clear"}, cfg_err, 0);
         seen = io.out_valid;
      end
      chk({tag, "_latency"}, n, WIDTH + 1);
      if (!seen) return;
      chk({tag, "_sum"}, io.sum, exp_s);
      chk({tag, "_cout"}, io.cout, exp_c);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_valid"}, io.out_valid, 1);
         chk({tag, "_hold_sum"}, {io.cout, io.sum}, {exp_c, exp_s});
      end
      @(negedge clk);
      io.out_ready = 1'b1;
      @(posedge clk); #1;
      io.out_ready = 1'b0;
      cnt_m       = cnt_m + 16'd1;
      last_sum_m  = exp_s;
      last_cout_m = exp_c;
      chk({tag, "_valid_drop"}, io.out_valid, 0);
      chk({tag, "_idle_in_ready"}, io.in_ready, 1);
      chk({tag, "_op_count"}, op_count, cnt_m);
      chk({tag, "_result_held"}, {io.cout, io.sum}, {last_cout_m, last_sum_m});
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tbl_ready"}, tbl_ready, 0);
      chk({tag, "_in_ready"}, io.in_ready, 0);
      chk({tag, "_out_valid"}, io.out_valid, 0);
      chk({tag, "_sum_cout"}, {io.cout, io.sum}, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cfg_err"}, cfg_err, 0);
      chk({tag, "_op_count"}, op_count, 0);
   endtask

   initial begin
      logic [WIDTH:0]   r;
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      bit               any_valid;

      io.in_valid = 1'b0; io.out_ready = 1'b0; io.a = '0; io.b = '0; io.cin = 1'b0;
      model_reset();
      #12;
      check_reset_outputs("por");
      @(negedge clk) rst = 1'b1;

      program_table(0);
      run_op("fa_b_6", 4'hB, 4'h6, 1'b1, 4'h2, 1'b1, 0, 1'b0);

      // Partial table: requests must be held off until the last entry lands.
      @(negedge clk) rst = 1'b0;
      model_reset();
      @(negedge clk) rst = 1'b1;
      for (int k = 0; k < 7; k++) cfg_write(3'(k), entry_for(0, k));
      @(negedge clk);
      io.in_valid = 1'b1; io.a = 4'h3; io.b = 4'h4; io.cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("partial_in_ready", io.in_ready, 0);
         chk("partial_busy", busy, 0);
      end
      cfg_write(3'd7, entry_for(0, 7));
      chk("eighth_tbl_ready", tbl_ready, 1);
      chk("eighth_in_ready", io.in_ready, 1);
      run_op("after_eighth", 4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 0, 1'b0);

      run_op("fa_f_1_stall", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 10, 1'b0);
      run_op("cfg_in_run", 4'h7, 4'h7, 1'b1, 4'hF, 1'b0, 1, 1'b1);

      program_table(1);
      run_op("xor_c0", 4'h5, 4'h3, 1'b0, 4'h6, 1'b0, 0, 1'b0);
      run_op("xor_c1", 4'h5, 4'h3, 1'b1, 4'h7, 1'b0, 0, 1'b0);

      // Reset while rippling.
      @(negedge clk);
      io.a = 4'h9; io.b = 4'h2; io.cin = 1'b0; io.in_valid = 1'b1;
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("midrun_busy", busy, 1);
      rst = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("midrun_rst");
      @(negedge clk) rst = 1'b1;
      any_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         any_valid = any_valid | io.out_valid;
      end
      chk("post_rst_no_valid", any_valid, 0);
      chk("post_rst_tbl_ready", tbl_ready, 0);

      program_table(0);
      force dut.op_count_q = 16'hFFFF;
      @(posedge clk); #1;
      release dut.op_count_q;
      cnt_m = 16'hFFFF;
      chk("forced_count", op_count, 16'hFFFF);
      run_op("wrap", 4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 0, 1'b0);

      for (int t = 0; t < 3; t++) begin
         program_table(2);
         for (int j = 0; j < 6; j++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            r  = ref_add(ra, rb, rc);
            run_op("rand", ra, rb, rc, r[WIDTH-1:0], r[WIDTH], int'($urandom_range(0, 3)), 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/cam_add_sequencer.md
Name: cam_add_sequencer

Overview:
- Controller for the CAM-lookup full-adder datapath.
- Owns the 8-entry truth-table storage and a cfg write port to program it.
- Accepts WIDTH-bit add requests over a valid/ready handshake. Ripples them one bit per cycle through table lookups, then returns sum and carry-out over a second valid/ready handshake.
- Sits between the requesting logic and the CAM adder table, replacing the free-running match pipeline with an explicitly sequenced one.

Parameters:
- WIDTH, 4, operand/sum width in bits; 1..32.
- NUM_CELL, 8, table entries; fixed at 8 = 2^3 for lookup key {a,b,c}.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  3  table entry index = {a,b,c}, a is MSB.
- cfg_data  in  2  entry value; bit0 = sum, bit1 = carry.
- cfg_err  out  1  one-cycle pulse: cfg write rejected.
- tbl_ready  out  1  all 8 entries written since reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- sum  out  WIDTH  result sum.
- cout  out  1  result carry-out.
- busy  out  1  state != IDLE.
- op_count  out  16  completed operations; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (rst=0, async): state=IDLE; table cleared to 2'b00; written-mask=0. All outputs 0: tbl_ready, in_ready, out_valid, sum, cout, busy, cfg_err, op_count.
- Reset mid-operation aborts: no out_valid, op_count unchanged (cleared), table must be reprogrammed.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = tbl_ready (combinational from registered mask).
  - On accept: latch a, b; carry_reg <= cin; idx <= 0; sum_reg <= 0; -> RUN.
- RUN, each cycle:
  - key = {a_q[idx], b_q[idx], carry_reg}.
  - sum_reg[idx] <= tbl[key][0]; carry_reg <= tbl[key][1].
  - if idx == WIDTH-1 -> DONE, else idx++.
  - Exactly WIDTH RUN cycles.
- DONE:
  - out_valid=1; sum=sum_reg; cout=carry_reg.
  - sum and cout held stable until out_ready=1. On that edge: -> IDLE, op_count++.
- Latency: out_valid rises WIDTH+1 rising edges after the accept edge (one edge into RUN, then WIDTH RUN cycles; entering DONE is the last RUN edge). Total: WIDTH edges into DONE after RUN entry.
- Throughput: in_ready=0 in DONE, so no back-to-back overlap. Min period is WIDTH+2 cycles with out_ready held high.
- sum/cout outside DONE: hold the last completed result (0 after reset).
- Config writes:
  - Accepted only in IDLE: tbl[cfg_addr] <= cfg_data; mask[cfg_addr] <= 1.
  - cfg_we in RUN/DONE: write ignored, cfg_err=1 next cycle for one cycle. The table is frozen during an operation.
  - Rewriting an entry is allowed; the mask stays set.
- Simultaneous cfg_we and in_valid in IDLE: both take effect at the same edge. Acceptance uses the pre-edge tbl_ready. The operation uses the post-write table (first lookup occurs in RUN).
- tbl_ready=0 -> in_ready=0; in_valid is ignored, no error.
- The table is fully programmable: non-adder contents produce whatever the table encodes. No arithmetic check is made.

Test Plan:
- Program standard full-adder table (entry k: sum=popcount(k)&1, carry=popcount(k)>=2). Then a=4'hB, b=4'h6, cin=1 -> out_valid after WIDTH+1 edges, sum=4'h2, cout=1, op_count=1.
- After reset with only 7 entries written: in_valid=1 -> in_ready=0, no busy. Write the 8th entry -> tbl_ready=1 next cycle, request accepted.
- Full-adder table, a=4'hF, b=4'h1, cin=0, out_ready=0 for 10 cycles -> out_valid held, sum=4'h0, cout=1 stable. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- During RUN, cfg_we=1, addr=3'b111, data=2'b00 -> cfg_err one-cycle pulse. The result is unaffected: a=4'h7, b=4'h7, cin=1 -> sum=4'hF, cout=0.
- XOR-only table (carry=0, sum=parity): a=4'h5, b=4'h3, cin=0 -> sum=4'h6, cout=0. With cin=1 -> sum=4'h7, cout=0.
- Assert rst=0 mid-RUN -> all outputs 0 immediately, tbl_ready=0, no out_valid after release. op_count wrap: force 16'hFFFF, complete one op -> 0.
